led_cmd_rx: RTL
===============

# led_cmd_rx

UART command receiver that sits directly upstream of the LED PWM brightness stage. It deserialises 8N1 bytes from a serial pin and parses 4-byte command frames. On each valid frame it emits a single-cycle write strobe carrying an LED index and an 8-bit brightness value. The PWM stage latches that value into its per-LED brightness register. Malformed, corrupted or stalled frames are discarded and flagged.

## Interface
Parameters:
- CLK_FREQ, 25_000_000: clk frequency in Hz.
- BAUD, 115_200: serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated, must be ≥ 4.
- TIMEOUT_BITS, 40: inter-byte timeout in bit times.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial input, idle high.
- wr_en  out  1  one-cycle strobe: valid command.
- wr_idx  out  3  LED index, valid while wr_en is high.
- wr_data  out  8  brightness value, valid while wr_en is high.
- err  out  1  one-cycle strobe: frame discarded.
- cmd_count  out  8  count of accepted commands; wraps 255→0.

## Operation
- Frame format: header 0xA5, index, value, checksum.
- Checksum = 0xA5 ^ index ^ value.
- Byte receiver:
  - rx passes through a 2-FF synchronizer.
  - The receiver arms on a synchronized high→low edge and samples at mid-bit (CLKS_PER_BIT/2 after the edge).
  - The start bit is re-checked at that mid-bit sample; a high sample is a glitch, so the receiver returns to idle silently.
  - 8 data bits are taken LSB first, each CLKS_PER_BIT apart, followed by the stop bit.
  - Stop = 1: byte_valid pulses with the byte.
  - Stop = 0: frame_err pulses and no byte is delivered.
- Parser FSM states: IDLE, IDX, VAL, CHK.
  - IDLE: byte 0xA5 → IDX. Any other byte is ignored, with no err.
  - IDX: byte[7:3] ≠ 0 → err, IDLE (0xA5 here is an error, not a resync). Otherwise store the index → VAL.
  - VAL: store the value → CHK.
  - CHK: checksum match → wr_en, cmd_count+1, IDLE. Mismatch → err, IDLE.
- Framing error in any state: err, parser to IDLE.
- Timeout:
  - A counter runs while the parser is not in IDLE and clears on each byte_valid.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT → err, IDLE.
- If a frame error and a timeout fall in the same cycle, only one err pulse is issued.
- wr_idx and wr_data hold their last written values between strobes.

## Timing
- Reset values:
  - Outputs: wr_en=0, err=0, wr_idx=0, wr_data=0, cmd_count=0.
  - Internals: FSM in IDLE, receiver idle, synchronizer flops = 1.
- byte_valid is asserted 1 cycle after the mid-stop-bit sample.
- wr_en and err are registered, asserted the cycle after the byte_valid that completes or breaks the frame.
- wr_en and err are never high in the same cycle.
- Minimum spacing between wr_en pulses is 40 bit times, with back-to-back frames.
- There is no backpressure: downstream must accept wr_en in the cycle it is asserted.
- Reset mid-byte or mid-frame discards the partial data. The first falling edge after release starts a new byte.

## Structure
- Shared package holds:
  - constants HDR_BYTE=8'hA5 and NUM_LEDS=8;
  - parser state encoding (2-bit enum).
  - The PWM stage imports NUM_LEDS from the same package.
- Sub-module uart_rx, parameterised by CLKS_PER_BIT:
  - contains the synchronizer, bit timer and shift register;
  - outputs byte_valid, byte_data, frame_err.
- The top level holds the parser FSM, the timeout counter and the output registers.

## Test plan
Bench settings: CLK_FREQ=1_600_000, BAUD=100_000 (16 clk/bit), TIMEOUT_BITS=40.
- Send A5 03 80 26 → single wr_en with wr_idx=3, wr_data=0x80; cmd_count=1; err stays 0.
- Send A5 07 FF 5D, then A5 00 00 A5 back-to-back → two wr_en pulses, (7,0xFF) then (0,0x00); cmd_count=2.
- Send A5 03 80 00 → one err pulse after the 4th byte; no wr_en; cmd_count unchanged.
- Send 11 22 (ignored), then A5 09 → err after byte 0x09. A following A5 02 40 E7 → wr_en with (2,0x40).
- Send A5 03, then idle for 40 bit times → err at the timeout. A following valid frame A5 01 10 B4 is accepted.
- Send a byte with stop bit 0 inside a frame → err, parser in IDLE. Assert rst_n low mid-frame → all outputs 0 and no wr_en from the partial frame. A frame sent after release is accepted.

Source files
------------

// File: rtl/led_cmd_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_cmd_rx_pkg
// Description : Shared constants, state encodings and checksum helper for the
//               LED command receiver and the PWM brightness stage.
// Revision    : 1.0 - initial release
// ============================================================================
package led_cmd_rx_pkg;

  // Frame header byte that opens every command frame
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Number of LED channels driven by the PWM stage
  localparam int NUM_LEDS = 8;

  // Width of the LED index field carried in a frame
  localparam int IDX_W = $clog2(NUM_LEDS);

  // Command parser states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IDX  = 2'd1,
    ST_VAL  = 2'd2,
    ST_CHK  = 2'd3
  } parser_state_t;

  // Byte receiver states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Checksum of a frame: header XOR index XOR value
  function automatic logic [7:0] frame_checksum(input logic [IDX_W-1:0] idx,
                                                input logic [7:0]       val);
    return HDR_BYTE ^ {{(8-IDX_W){1'b0}}, idx} ^ val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_cmd_rx_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 byte receiver. Synchronises the serial pin, detects the
//               start edge, samples each bit at mid-bit and reports either a
//               good byte or a framing error (stop bit low).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import led_cmd_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync_prev;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_frame_err;
  logic             w_fall;

  // A start bit begins on a synchronised high-to-low transition
  assign w_fall = r_sync_prev & ~r_sync2;

  // Two-flop synchroniser plus one history flop for edge detection; idle-high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= rx;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  // Bit timer and shift register: half a bit to the start-bit centre, then full bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            // A line already back high at mid-start is a glitch; drop it quietly
            if (r_sync2) begin
              r_state <= RX_IDLE;
            end else begin
              r_state   <= RX_DATA;
              r_bit_cnt <= 3'd0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= RX_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync2) begin
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_shift;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/led_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : led_cmd_rx
// Description : UART command receiver for the LED PWM stage. Parses 4-byte
//               frames (A5, index, value, checksum) and issues a one-cycle
//               write strobe per valid frame; bad or stalled frames raise err.
// Revision    : 1.0 - initial release
// ============================================================================
module led_cmd_rx
  import led_cmd_rx_pkg::*;
#(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int BAUD         = 115_200,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       wr_en,
  output logic [2:0] wr_idx,
  output logic [7:0] wr_data,
  output logic       err,
  output logic [7:0] cmd_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  logic             w_byte_valid;
  logic [7:0]       w_byte_data;
  logic             w_frame_err;
  logic             w_timeout;

  parser_state_t    r_state;
  logic [TO_W-1:0]  r_to_cnt;
  logic [IDX_W-1:0] r_idx_buf;
  logic [7:0]       r_val_buf;
  logic             r_wr_en;
  logic [2:0]       r_wr_idx;
  logic [7:0]       r_wr_data;
  logic             r_err;
  logic [7:0]       r_cmd_count;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .frame_err  (w_frame_err)
  );

  // The inter-byte window expires on its last count unless a byte lands that cycle
  assign w_timeout = (r_state != ST_IDLE) && !w_byte_valid && (r_to_cnt == TO_LAST);

  // Inter-byte timeout counter: runs only mid-frame, restarts on every good byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_IDLE) || w_byte_valid) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Frame parser with registered strobes; framing error and timeout share one err pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx_buf   <= '0;
      r_val_buf   <= 8'h00;
      r_wr_en     <= 1'b0;
      r_wr_idx    <= 3'd0;
      r_wr_data   <= 8'h00;
      r_err       <= 1'b0;
      r_cmd_count <= 8'h00;
    end else begin
      r_wr_en <= 1'b0;
      r_err   <= 1'b0;
      if (w_frame_err || w_timeout) begin
        r_err   <= 1'b1;
        r_state <= ST_IDLE;
      end else if (w_byte_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (w_byte_data == HDR_BYTE) begin
              r_state <= ST_IDX;
            end
          end
          ST_IDX: begin
            // An out-of-range index (including a repeated header) kills the frame
            if (w_byte_data[7:IDX_W] != '0) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_idx_buf <= w_byte_data[IDX_W-1:0];
              r_state   <= ST_VAL;
            end
          end
          ST_VAL: begin
            r_val_buf <= w_byte_data;
            r_state   <= ST_CHK;
          end
          ST_CHK: begin
            if (w_byte_data == frame_checksum(r_idx_buf, r_val_buf)) begin
              r_wr_en     <= 1'b1;
              r_wr_idx    <= r_idx_buf;
              r_wr_data   <= r_val_buf;
              r_cmd_count <= r_cmd_count + 8'd1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_idx    = r_wr_idx;
  assign wr_data   = r_wr_data;
  assign err       = r_err;
  assign cmd_count = r_cmd_count;

endmodule
`default_nettype wire
